// File: rtl/busy_table_mp_pkg.sv
// Shared ISU definitions for the busy table: ROB state codes, default register-file
// geometry and the recovery FSM state encoding.
package busy_table_mp_pkg;

  localparam int BT_PREG_NUM_DEF = 64;
  localparam int BT_PREG_AW_DEF  = $clog2(BT_PREG_NUM_DEF);

  localparam logic [1:0] ROB_STATE_IDLE      = 2'd0;
  localparam logic [1:0] ROB_STATE_ROLLIBACK = 2'd1;
  localparam logic [1:0] ROB_STATE_WALK      = 2'd2;

  typedef enum logic [1:0] {
    BT_NORMAL = 2'd0,
    BT_CLEAR  = 2'd1,
    BT_WALK   = 2'd2
  } bt_state_e;

endpackage

// File: rtl/bt_popcount.sv
// Combinational population count of the busy vector; feeds the registered busy_count.
module bt_popcount #(
  parameter int PREG_NUM = 64,
  parameter int PREG_AW  = 6
) (
  input  logic [PREG_NUM-1:0] vec,
  output logic [PREG_AW:0]    count
);

  // Sum of all set bits.
  always_comb begin
    count = {(PREG_AW+1){1'b0}};
    for (int i = 0; i < PREG_NUM; i++) begin
      count = count + {{PREG_AW{1'b0}}, vec[i]};
    end
  end

endmodule

// File: rtl/busy_table_mp.sv
// Multi-port physical-register busy table with ROB rollback/walk recovery FSM.
// Optional same-cycle read bypass: define BUSY_TABLE_BYPASS_EN.
module busy_table_mp
  import busy_table_mp_pkg::*;
#(
  parameter int PREG_NUM    = BT_PREG_NUM_DEF,
  parameter int PREG_AW     = $clog2(PREG_NUM),
  parameter int RD_PORTS    = 4,
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2,
  parameter int WALK_PORTS  = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [RD_PORTS*PREG_AW-1:0]    rd_addr,
  output logic [RD_PORTS-1:0]            rd_busy,
  input  logic [ALLOC_PORTS-1:0]         alloc_en,
  input  logic [ALLOC_PORTS*PREG_AW-1:0] alloc_addr,
  input  logic [FREE_PORTS-1:0]          free_en,
  input  logic [FREE_PORTS*PREG_AW-1:0]  free_addr,
  input  logic [WALK_PORTS-1:0]          walk_valid,
  input  logic [WALK_PORTS-1:0]          walk_complete,
  input  logic [WALK_PORTS*PREG_AW-1:0]  walk_prd,
  input  logic [1:0]                     rob_state,
  output logic                           recovering,
  output logic [PREG_AW:0]               busy_count
);

  bt_state_e             state_r, state_nxt_s;
  logic [PREG_NUM-1:0]   busy_r, busy_nxt_s, set_s, free_s, rd_src_s;
  logic [PREG_AW:0]      count_nxt_s, busy_count_r;
  logic                  recovering_r, clear_all_s, alloc_ok_s, walk_ok_s;

  // Recovery FSM next state and the clear-all strobe on entry to CLEAR.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BT_NORMAL: begin
        if (rob_state == ROB_STATE_ROLLIBACK) state_nxt_s = BT_CLEAR;
        else                                  state_nxt_s = state_r;
      end
      BT_CLEAR: begin
        if (rob_state == ROB_STATE_WALK)      state_nxt_s = BT_WALK;
        else if (rob_state == ROB_STATE_IDLE) state_nxt_s = BT_NORMAL;
        else                                  state_nxt_s = state_r;
      end
      BT_WALK: begin
        if (rob_state == ROB_STATE_IDLE)           state_nxt_s = BT_NORMAL;
        else if (rob_state == ROB_STATE_ROLLIBACK) state_nxt_s = BT_CLEAR;
        else                                       state_nxt_s = state_r;
      end
      default: state_nxt_s = BT_NORMAL;
    endcase
    clear_all_s = (state_nxt_s == BT_CLEAR) && (state_r != BT_CLEAR);
    alloc_ok_s  = !recovering_r && (rob_state == ROB_STATE_IDLE);
    walk_ok_s   = (state_r == BT_WALK);
  end

  // Per-entry hit decode across all alloc, walk and free ports.
  always_comb begin
    set_s  = {PREG_NUM{1'b0}};
    free_s = {PREG_NUM{1'b0}};
    for (int j = 0; j < PREG_NUM; j++) begin
      for (int p = 0; p < ALLOC_PORTS; p++) begin
        set_s[j] = set_s[j] | (alloc_ok_s & alloc_en[p] &
                   (alloc_addr[p*PREG_AW +: PREG_AW] == PREG_AW'(j)));
      end
      for (int p = 0; p < WALK_PORTS; p++) begin
        set_s[j] = set_s[j] | (walk_ok_s & walk_valid[p] & ~walk_complete[p] &
                   (walk_prd[p*PREG_AW +: PREG_AW] == PREG_AW'(j)));
      end
      for (int p = 0; p < FREE_PORTS; p++) begin
        free_s[j] = free_s[j] | (free_en[p] &
                    (free_addr[p*PREG_AW +: PREG_AW] == PREG_AW'(j)));
      end
    end
  end

  // Next-state vector: clear-all, then set, then free; entry 0 is never busy.
  always_comb begin
    busy_nxt_s = {PREG_NUM{1'b0}};
    for (int j = 0; j < PREG_NUM; j++) begin
      if (j == 0)          busy_nxt_s[j] = 1'b0;
      else if (clear_all_s) busy_nxt_s[j] = 1'b0;
      else if (set_s[j])   busy_nxt_s[j] = 1'b1;
      else if (free_s[j])  busy_nxt_s[j] = 1'b0;
      else                 busy_nxt_s[j] = busy_r[j];
    end
  end

  bt_popcount #(
    .PREG_NUM (PREG_NUM),
    .PREG_AW  (PREG_AW)
  ) u_popcount (
    .vec   (busy_nxt_s),
    .count (count_nxt_s)
  );

`ifdef BUSY_TABLE_BYPASS_EN
  assign rd_src_s = busy_nxt_s;
`else
  assign rd_src_s = busy_r;
`endif

  // Lookup ports; address 0 always reads not-busy.
  always_comb begin
    rd_busy = {RD_PORTS{1'b0}};
    for (int i = 0; i < RD_PORTS; i++) begin
      if (rd_addr[i*PREG_AW +: PREG_AW] == {PREG_AW{1'b0}}) rd_busy[i] = 1'b0;
      else rd_busy[i] = rd_src_s[rd_addr[i*PREG_AW +: PREG_AW]];
    end
  end

  // State, vector and count registers updated together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= BT_NORMAL;
      busy_r       <= {PREG_NUM{1'b0}};
      busy_count_r <= {(PREG_AW+1){1'b0}};
      recovering_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      busy_r       <= busy_nxt_s;
      busy_count_r <= count_nxt_s;
      recovering_r <= (state_nxt_s != BT_NORMAL);
    end
  end

  assign recovering = recovering_r;
  assign busy_count = busy_count_r;

endmodule

// File: tb/tb_busy_table_mp.sv
// Self-checking bench for busy_table_mp: directed scenarios plus randomized traffic
// against an array-based reference model of the busy-table rules.
module tb_busy_table_mp;
  import busy_table_mp_pkg::*;

  localparam int N  = 64;
  localparam int AW = 6;
  localparam int RP = 4;
  localparam int AP = 2;
  localparam int FP = 2;
  localparam int WP = 2;

  localparam int PH_RUN    = 0;
  localparam int PH_FLUSH  = 1;
  localparam int PH_REPLAY = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [RP*AW-1:0]  rd_addr;
  logic [RP-1:0]     rd_busy;
  logic [AP-1:0]     alloc_en;
  logic [AP*AW-1:0]  alloc_addr;
  logic [FP-1:0]     free_en;
  logic [FP*AW-1:0]  free_addr;
  logic [WP-1:0]     walk_valid;
  logic [WP-1:0]     walk_complete;
  logic [WP*AW-1:0]  walk_prd;
  logic [1:0]        rob_state;
  logic              recovering;
  logic [AW:0]       busy_count;

  int n_checks = 0;
  int n_errors = 0;

  bit mdl_busy [N];
  bit mdl_nxt  [N];
  int mdl_ph = PH_RUN;
  int mdl_ph_nxt = PH_RUN;

  busy_table_mp dut (
    .clock         (clock),
    .reset         (reset),
    .rd_addr       (rd_addr),
    .rd_busy       (rd_busy),
    .alloc_en      (alloc_en),
    .alloc_addr    (alloc_addr),
    .free_en       (free_en),
    .free_addr     (free_addr),
    .walk_valid    (walk_valid),
    .walk_complete (walk_complete),
    .walk_prd      (walk_prd),
    .rob_state     (rob_state),
    .recovering    (recovering),
    .busy_count    (busy_count)
  );

  always #5 clock = ~clock;

  // Reference model: next table contents and recovery phase from current inputs.
  function automatic void mdl_calc();
    bit entering;
    if (reset) begin
      for (int j = 0; j < N; j++) mdl_nxt[j] = 1'b0;
      mdl_ph_nxt = PH_RUN;
    end else begin
      mdl_ph_nxt = mdl_ph;
      if (mdl_ph == PH_RUN) begin
        if (rob_state == ROB_STATE_ROLLIBACK) mdl_ph_nxt = PH_FLUSH;
      end else if (mdl_ph == PH_FLUSH) begin
        if (rob_state == ROB_STATE_WALK) mdl_ph_nxt = PH_REPLAY;
        else if (rob_state == ROB_STATE_IDLE) mdl_ph_nxt = PH_RUN;
      end else begin
        if (rob_state == ROB_STATE_IDLE) mdl_ph_nxt = PH_RUN;
        else if (rob_state == ROB_STATE_ROLLIBACK) mdl_ph_nxt = PH_FLUSH;
      end
      entering = (mdl_ph_nxt == PH_FLUSH) && (mdl_ph != PH_FLUSH);
      for (int j = 0; j < N; j++) mdl_nxt[j] = entering ? 1'b0 : mdl_busy[j];
      if (!entering) begin
        for (int p = 0; p < FP; p++)
          if (free_en[p]) mdl_nxt[free_addr[p*AW +: AW]] = 1'b0;
        if (mdl_ph == PH_REPLAY)
          for (int p = 0; p < WP; p++)
            if (walk_valid[p] && !walk_complete[p]) mdl_nxt[walk_prd[p*AW +: AW]] = 1'b1;
        if (mdl_ph == PH_RUN && rob_state == ROB_STATE_IDLE)
          for (int p = 0; p < AP; p++)
            if (alloc_en[p]) mdl_nxt[alloc_addr[p*AW +: AW]] = 1'b1;
      end
      mdl_nxt[0] = 1'b0;
    end
  endfunction

  function automatic int mdl_count();
    int c = 0;
    for (int j = 0; j < N; j++) c += int'(mdl_busy[j]);
    return c;
  endfunction

  function automatic bit mdl_read(input int a);
`ifdef BUSY_TABLE_BYPASS_EN
    mdl_calc();
    return (a == 0) ? 1'b0 : mdl_nxt[a];
`else
    return (a == 0) ? 1'b0 : mdl_busy[a];
`endif
  endfunction

  task automatic step();
    mdl_calc();
    @(posedge clock);
    mdl_busy = mdl_nxt;
    mdl_ph   = mdl_ph_nxt;
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; alloc_en = '0; free_en = '0; walk_valid = '0; walk_complete = '0;
    rob_state = ROB_STATE_IDLE;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic set_alloc(input int p, input int a);
    alloc_en[p] = 1'b1; alloc_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic set_free(input int p, input int a);
    free_en[p] = 1'b1; free_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic set_walk(input int p, input int a, input bit done);
    walk_valid[p] = 1'b1; walk_complete[p] = done; walk_prd[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    rd_addr = '0; alloc_addr = '0; free_addr = '0; walk_prd = '0;
    do_reset();
    n_checks++;
    if (busy_count !== 7'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", busy_count); end
    n_checks++;
    if (recovering !== 1'b0) begin n_errors++; $display("FAIL reset_recovering: got %b expected 0", recovering); end
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < RP; p++) set_rd(p, k * RP + p + 1);
      #1;
      n_checks++;
      if (rd_busy !== 4'b0000) begin n_errors++; $display("FAIL reset_rd: got %b expected 0000", rd_busy); end
    end
  endtask

  task automatic test_alloc_basic();
    bit exp_byp;
`ifdef BUSY_TABLE_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif
    idle_inputs();
    set_alloc(0, 5); set_alloc(1, 9);
    set_rd(0, 5);
    #1;
    n_checks++;
    if (rd_busy[0] !== exp_byp) begin n_errors++; $display("FAIL alloc_same_cycle: got %b expected %b", rd_busy[0], exp_byp); end
    step();
    idle_inputs();
    set_rd(0, 5); set_rd(1, 9); set_rd(2, 6); set_rd(3, 0);
    #1;
    n_checks++;
    if (rd_busy !== 4'b0011) begin n_errors++; $display("FAIL alloc_rd: got %b expected 0011", rd_busy); end
    n_checks++;
    if (busy_count !== 7'd2) begin n_errors++; $display("FAIL alloc_count: got %0d expected 2", busy_count); end
  endtask

  task automatic test_set_beats_clear();
    idle_inputs();
    set_alloc(0, 12);
    step();
    idle_inputs();
    set_free(0, 12); set_alloc(1, 12);
    step();
    idle_inputs();
    set_rd(0, 12);
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1) begin n_errors++; $display("FAIL set_beats_clear_rd: got %b expected 1", rd_busy[0]); end
    n_checks++;
    if (busy_count !== 7'd3) begin n_errors++; $display("FAIL set_beats_clear_count: got %0d expected 3", busy_count); end
    set_free(0, 12);
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0) begin n_errors++; $display("FAIL free_rd: got %b expected 0", rd_busy[0]); end
    n_checks++;
    if (busy_count !== 7'd2) begin n_errors++; $display("FAIL free_count: got %0d expected 2", busy_count); end
  endtask

  task automatic test_addr_zero();
    do_reset();
    set_alloc(0, 0); set_alloc(1, 0);
    set_rd(0, 0);
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0) begin n_errors++; $display("FAIL zero_same_cycle: got %b expected 0", rd_busy[0]); end
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0) begin n_errors++; $display("FAIL zero_rd: got %b expected 0", rd_busy[0]); end
    n_checks++;
    if (busy_count !== 7'd0) begin n_errors++; $display("FAIL zero_count: got %0d expected 0", busy_count); end
  endtask

  task automatic test_recovery();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_alloc(0, 20 + 2 * k); set_alloc(1, 21 + 2 * k);
      step();
    end
    idle_inputs();
    n_checks++;
    if (busy_count !== 7'd10) begin n_errors++; $display("FAIL rec_fill_count: got %0d expected 10", busy_count); end
    rob_state = ROB_STATE_ROLLIBACK;
    step();
    n_checks++;
    if (busy_count !== 7'd0 || recovering !== 1'b1) begin
      n_errors++; $display("FAIL rec_clear: got count %0d rec %b expected count 0 rec 1", busy_count, recovering);
    end
    rob_state = ROB_STATE_WALK;
    set_walk(0, 3, 1'b0); set_walk(1, 4, 1'b1);
    step();
    step();
    walk_valid = '0;
    set_rd(0, 3); set_rd(1, 4);
    #1;
    n_checks++;
    if (rd_busy[1:0] !== 2'b01) begin n_errors++; $display("FAIL rec_walk_rd: got %b expected 01", rd_busy[1:0]); end
    n_checks++;
    if (busy_count !== 7'd1 || recovering !== 1'b1) begin
      n_errors++; $display("FAIL rec_walk_state: got count %0d rec %b expected count 1 rec 1", busy_count, recovering);
    end
    rob_state = ROB_STATE_IDLE;
    step();
    n_checks++;
    if (recovering !== 1'b0) begin n_errors++; $display("FAIL rec_exit: got %b expected 0", recovering); end
  endtask

  task automatic test_nested_flush();
    idle_inputs();
    rob_state = ROB_STATE_ROLLIBACK;
    step();
    rob_state = ROB_STATE_WALK;
    step();
    set_walk(0, 11, 1'b0);
    set_alloc(1, 7);
    step();
    idle_inputs();
    rob_state = ROB_STATE_WALK;
    set_rd(0, 7); set_rd(1, 11);
    #1;
    n_checks++;
    if (rd_busy[1:0] !== 2'b10 || busy_count !== 7'd1) begin
      n_errors++; $display("FAIL walk_alloc_ignored: got rd %b count %0d expected rd 10 count 1", rd_busy[1:0], busy_count);
    end
    rob_state = ROB_STATE_ROLLIBACK;
    step();
    n_checks++;
    if (busy_count !== 7'd0 || recovering !== 1'b1) begin
      n_errors++; $display("FAIL nested_clear: got count %0d rec %b expected count 0 rec 1", busy_count, recovering);
    end
    rob_state = 2'd3;
    set_walk(0, 13, 1'b0);
    step();
    walk_valid = '0;
    n_checks++;
    if (busy_count !== 7'd0 || recovering !== 1'b1) begin
      n_errors++; $display("FAIL nested_in_clear: got count %0d rec %b expected count 0 rec 1", busy_count, recovering);
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid_walk();
    idle_inputs();
    rob_state = ROB_STATE_ROLLIBACK;
    step();
    rob_state = ROB_STATE_WALK;
    step();
    for (int k = 0; k < 3; k++) begin
      set_walk(0, 40 + 2 * k, 1'b0); set_walk(1, 41 + 2 * k, 1'b0);
      step();
    end
    walk_valid = '0;
    n_checks++;
    if (busy_count !== 7'd6) begin n_errors++; $display("FAIL mid_walk_fill: got %0d expected 6", busy_count); end
    reset = 1'b1;
    step();
    n_checks++;
    if (busy_count !== 7'd0 || recovering !== 1'b0) begin
      n_errors++; $display("FAIL mid_walk_reset: got count %0d rec %b expected count 0 rec 0", busy_count, recovering);
    end
    idle_inputs();
    for (int p = 0; p < RP; p++) set_rd(p, 40 + p);
    #1;
    n_checks++;
    if (rd_busy !== 4'b0000) begin n_errors++; $display("FAIL mid_walk_rd: got %b expected 0000", rd_busy); end
    step();
  endtask

  task automatic test_random();
    int a;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) rob_state = 2'($urandom_range(0, 3));
      alloc_en = AP'($urandom); free_en = FP'($urandom);
      walk_valid = WP'($urandom); walk_complete = WP'($urandom);
      for (int p = 0; p < AP; p++) alloc_addr[p*AW +: AW] = AW'($urandom_range(0, 15));
      for (int p = 0; p < FP; p++) free_addr[p*AW +: AW] = AW'($urandom_range(0, 15));
      for (int p = 0; p < WP; p++) walk_prd[p*AW +: AW] = AW'($urandom_range(0, 15));
      for (int p = 0; p < RP; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 15));
      #1;
      for (int p = 0; p < RP; p++) begin
        a = int'(rd_addr[p*AW +: AW]);
        n_checks++;
        if (rd_busy[p] !== mdl_read(a)) begin
          n_errors++; $display("FAIL rand_rd cyc %0d port %0d addr %0d: got %b expected %b", c, p, a, rd_busy[p], mdl_read(a));
        end
      end
      step();
      n_checks++;
      if (busy_count !== 7'(mdl_count())) begin
        n_errors++; $display("FAIL rand_count cyc %0d: got %0d expected %0d", c, busy_count, mdl_count());
      end
      n_checks++;
      if (recovering !== (mdl_ph != PH_RUN)) begin
        n_errors++; $display("FAIL rand_recovering cyc %0d: got %b expected %b", c, recovering, mdl_ph != PH_RUN);
      end
    end
    idle_inputs();
    rob_state = 2'd3;
    for (int base = 0; base < N; base += RP) begin
      for (int p = 0; p < RP; p++) set_rd(p, base + p);
      #1;
      for (int p = 0; p < RP; p++) begin
        n_checks++;
        if (rd_busy[p] !== mdl_read(base + p)) begin
          n_errors++; $display("FAIL rand_scan addr %0d: got %b expected %b", base + p, rd_busy[p], mdl_read(base + p));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alloc_basic();
    test_set_beats_clear();
    test_addr_zero();
    test_recovery();
    test_nested_flush();
    test_reset_mid_walk();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
